// File: rtl/exp5_mostra_sequencia_if.sv
// Bus between the playback unit and its environment (control unit, ROM, LEDs).
//   iniciar    : start playback (controller -> unit)
//   limite     : last ROM address to show, inclusive
//   dado_mem   : ROM data at endereco, one-hot LED pattern
//   endereco   : ROM address (unit -> ROM)
//   leds       : LED drive
//   mostrando  : playback in progress
//   fim_mostra : one-cycle completion pulse
//   db_estado  : state code for the debug display
//   abortar    : abort playback, only with MOSTRA_ABORTA_EN defined
// Optional feature macro: MOSTRA_ABORTA_EN.
interface exp5_mostra_sequencia_if;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       mostrando;
  logic       fim_mostra;
  logic [3:0] db_estado;
`ifdef MOSTRA_ABORTA_EN
  logic       abortar;
`endif

  modport master (
`ifdef MOSTRA_ABORTA_EN
    output abortar,
`endif
    output iniciar, limite, dado_mem,
    input  endereco, leds, mostrando, fim_mostra, db_estado
  );

  modport slave (
`ifdef MOSTRA_ABORTA_EN
    input  abortar,
`endif
    input  iniciar, limite, dado_mem,
    output endereco, leds, mostrando, fim_mostra, db_estado
  );
endinterface

// File: rtl/exp5_mostra_sequencia.sv
// Memory-game playback unit: walks the ROM from address 0 up to a latched
// limit and shows each entry on the LEDs for T_ACESO cycles followed by a
// T_APAGADO-cycle dark gap, then pulses fim_mostra for one cycle.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active high
//   bus   : exp5_mostra_sequencia_if.slave (iniciar, limite, dado_mem in;
//           endereco, leds, mostrando, fim_mostra, db_estado out;
//           abortar in when MOSTRA_ABORTA_EN is defined)
// Optional feature macro: MOSTRA_ABORTA_EN (abort input).
module exp5_mostra_sequencia #(
  parameter int unsigned T_ACESO   = 50,
  parameter int unsigned T_APAGADO = 25
) (
  input  logic                    clock,
  input  logic                    reset,
  exp5_mostra_sequencia_if.slave  bus
);

  localparam int unsigned TIMER_W = 16;
  localparam logic [TIMER_W-1:0] ACESO_ULT   = TIMER_W'(T_ACESO - 1);
  localparam logic [TIMER_W-1:0] APAGADO_ULT = TIMER_W'(T_APAGADO - 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  estado_t              estado;
  logic [3:0]           limite_reg;
  logic [3:0]           dado_reg;
  logic [TIMER_W-1:0]   timer;
  logic                 abortar_c;

`ifdef MOSTRA_ABORTA_EN
  assign abortar_c = bus.abortar;
`else
  assign abortar_c = 1'b0;
`endif

  // State register and registered outputs; db_estado/mostrando follow the
  // next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= OCIOSO;
      limite_reg     <= 4'd0;
      dado_reg       <= 4'd0;
      timer          <= '0;
      bus.endereco   <= 4'd0;
      bus.leds       <= 4'd0;
      bus.mostrando  <= 1'b0;
      bus.fim_mostra <= 1'b0;
      bus.db_estado  <= 4'h0;
    end else begin
      bus.fim_mostra <= 1'b0;
      if (abortar_c && (estado != OCIOSO) && (estado != FIM)) begin
        // Abort wins over every other transition; no completion pulse.
        estado        <= OCIOSO;
        timer         <= '0;
        bus.endereco  <= 4'd0;
        bus.leds      <= 4'd0;
        bus.mostrando <= 1'b0;
        bus.db_estado <= OCIOSO;
      end else begin
        case (estado)
          OCIOSO: begin
            bus.db_estado <= OCIOSO;
            if (bus.iniciar) begin
              estado        <= CARREGA;
              bus.endereco  <= 4'd0;
              limite_reg    <= bus.limite;
              bus.mostrando <= 1'b1;
              bus.db_estado <= CARREGA;
            end
          end
          CARREGA: begin
            // leds loads straight from the ROM so the pattern is visible
            // from the first ACENDE cycle; dado_reg keeps it afterwards.
            dado_reg      <= bus.dado_mem;
            bus.leds      <= bus.dado_mem;
            timer         <= '0;
            estado        <= ACENDE;
            bus.db_estado <= ACENDE;
          end
          ACENDE: begin
            if (timer == ACESO_ULT) begin
              timer         <= '0;
              bus.leds      <= 4'd0;
              estado        <= APAGA;
              bus.db_estado <= APAGA;
            end else begin
              timer    <= timer + TIMER_W'(1);
              bus.leds <= dado_reg;
            end
          end
          APAGA: begin
            bus.leds <= 4'd0;
            if (timer == APAGADO_ULT) begin
              timer <= '0;
              if (bus.endereco == limite_reg) begin
                estado         <= FIM;
                bus.fim_mostra <= 1'b1;
                bus.db_estado  <= FIM;
              end else begin
                estado        <= PROXIMO;
                bus.db_estado <= PROXIMO;
              end
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          PROXIMO: begin
            bus.endereco  <= bus.endereco + 4'd1;
            estado        <= CARREGA;
            bus.db_estado <= CARREGA;
          end
          FIM: begin
            // endereco keeps the last address shown.
            estado        <= OCIOSO;
            bus.mostrando <= 1'b0;
            bus.db_estado <= OCIOSO;
          end
          default: begin
            // Illegal code: recover to idle and flag it on the display.
            estado        <= OCIOSO;
            timer         <= '0;
            bus.leds      <= 4'd0;
            bus.mostrando <= 1'b0;
            bus.db_estado <= 4'hE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exp5_mostra_sequencia.sv
// Directed bench for exp5_mostra_sequencia with T_ACESO=3, T_APAGADO=2.
// Each step lasts 7 cycles (CARREGA, 3x ACENDE, 2x APAGA, PROXIMO); the last
// step replaces PROXIMO with FIM.
module tb_exp5_mostra_sequencia;

  localparam int TA   = 3;
  localparam int TP   = 2;
  localparam int PASO = TA + TP + 2;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [3:0] rom [16];

  exp5_mostra_sequencia_if bus ();

  assign bus.dado_mem = rom[bus.endereco];

  exp5_mostra_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] db, input logic [3:0] ld,
                         input logic [3:0] en, input logic fm, input logic mo);
    chk({tag, " db_estado"}, bus.db_estado, db);
    chk({tag, " leds"}, bus.leds, ld);
    chk({tag, " endereco"}, bus.endereco, en);
    chk({tag, " fim_mostra"}, {3'b000, bus.fim_mostra}, {3'b000, fm});
    chk({tag, " mostrando"}, {3'b000, bus.mostrando}, {3'b000, mo});
  endtask

  // Start a playback and check every cycle until one past fim_mostra.
  // With disturb set, limite and iniciar are wiggled mid-playback.
  task automatic run_play(input logic [3:0] lim, input bit disturb);
    int f;
    int s;
    int p;
    logic [3:0] e_db;
    logic [3:0] e_ld;
    logic [3:0] e_en;
    logic       e_fm;
    logic       e_mo;
    f = (int'(lim) + 1) * PASO;
    bus.limite  = lim;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int c = 1; c <= f + 1; c++) begin
      e_ld = 4'h0;
      e_fm = 1'b0;
      e_mo = 1'b1;
      if (c == f + 1) begin
        e_db = 4'h0; e_en = lim; e_mo = 1'b0;
      end else if (c == f) begin
        e_db = 4'hF; e_en = lim; e_fm = 1'b1;
      end else begin
        s = (c - 1) / PASO;
        p = (c - 1) % PASO;
        e_en = 4'(s);
        if (p == 0)           e_db = 4'h1;
        else if (p < 1 + TA)  begin e_db = 4'h2; e_ld = rom[s]; end
        else if (p < PASO - 1) e_db = 4'h3;
        else                   e_db = 4'h4;
      end
      chk_all($sformatf("lim%0d c%0d", lim, c), e_db, e_ld, e_en, e_fm, e_mo);
      if (disturb && c == 5) begin
        bus.limite  = 4'd5;
        bus.iniciar = 1'b1;
      end
      if (disturb && c == 6) bus.iniciar = 1'b0;
      if (c <= f) tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) rom[i] = 4'h0;
    rom[0] = 4'b0001;
    rom[1] = 4'b0010;
    rom[2] = 4'b0100;
    rom[3] = 4'b1000;
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.limite  = 4'd0;
`ifdef MOSTRA_ABORTA_EN
    bus.abortar = 1'b0;
`endif

    // Reset state, then idle with iniciar low.
    @(negedge clock);
    chk_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("idle%0d", i), 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    end

    // Single step, fim_mostra in cycle 7.
    run_play(4'd0, 1'b0);

    // Three steps, fim_mostra in cycle 21.
    run_play(4'd2, 1'b0);

    // limite change and re-iniciar during playback are ignored.
    run_play(4'd2, 1'b1);
    tick();
    chk_all("post-disturb idle", 4'h0, 4'h0, 4'd2, 1'b0, 1'b0);

    // Reset during ACENDE of step 1 (cycle 9).
    bus.limite  = 4'd2;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    chk_all("pre-reset c9", 4'h2, 4'b0010, 4'd1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk_all("mid reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    run_play(4'd1, 1'b0);

`ifdef MOSTRA_ABORTA_EN
    // Abort during APAGA of step 0: back to idle, no completion pulse.
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    chk_all("pre-abort c5", 4'h3, 4'h0, 4'd0, 1'b0, 1'b1);
    bus.abortar = 1'b1;
    tick();
    bus.abortar = 1'b0;
    chk_all("abort", 4'h0, 4'h0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_all($sformatf("post-abort%0d", i), 4'h0, 4'h0, 4'd0, 1'b0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp5_mostra_sequencia.md
Name: exp5_mostra_sequencia

Overview:
- Playback unit for the memory game. It reads the stored sequence from the game ROM and shows it on the LEDs, one entry per step, from address 0 up to the current round limit.
- It is the output-side counterpart of the play-checking control unit, which reads player button presses.
- It sits between the round counter (which supplies the limit) and the LED drivers.
- It raises a one-cycle done pulse so the control unit can move into its wait-for-play state.

Parameters:
- T_ACESO, default 50, LED-on duration in clock cycles. Legal range 1..65535.
- T_APAGADO, default 25, LED-off gap after each step in clock cycles. Legal range 1..65535.

Ports:
- clock, input, 1: system clock, rising-edge triggered.
- reset, input, 1: asynchronous, active-high; forces the reset state below.
- iniciar, input, 1: start playback. Sampled only in OCIOSO.
- limite, input, 4: last address to show, inclusive. Latched when iniciar is sampled.
- dado_mem, input, 4: ROM data at endereco, combinational read, one-hot LED pattern.
- endereco, output, 4: ROM address, registered.
- leds, output, 4: LED drive, registered.
- mostrando, output, 1: high in every state except OCIOSO.
- fim_mostra, output, 1: one-cycle pulse when playback completes.
- db_estado, output, 4: state code for the debug display.
- abortar, input, 1: present only with MOSTRA_ABORTA_EN.

Behaviour:
- Reset (async): state=OCIOSO, endereco=0, leds=0, limite_reg=0, timer=0, fim_mostra=0, mostrando=0.
- State codes (db_estado): OCIOSO=0, CARREGA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=F. Any illegal code goes to OCIOSO and shows E.
- Timer: 16-bit, zeroed on entry to ACENDE and to APAGA, increments every cycle while in either state.
- Transitions:
  - OCIOSO: iniciar=1 → CARREGA; endereco<=0, limite_reg<=limite. Otherwise stay.
  - CARREGA: one cycle; dado_reg<=dado_mem → ACENDE.
  - ACENDE: leds=dado_reg; when timer==T_ACESO-1 → APAGA.
  - APAGA: leds=0; when timer==T_APAGADO-1 → FIM if endereco==limite_reg, else PROXIMO.
  - PROXIMO: one cycle; endereco<=endereco+1 → CARREGA.
  - FIM: one cycle; fim_mostra=1 → OCIOSO. endereco holds its last value.
- Step timing: each non-final step takes 1+T_ACESO+T_APAGADO+1 cycles. The final step takes 1+T_ACESO+T_APAGADO cycles, then FIM.
- Latency: with iniciar sampled at edge 0, fim_mostra is high in cycle (limite+1)·(T_ACESO+T_APAGADO+2).
- leds is 0 in every state except ACENDE.
- dado_mem=0 is still a full-length step with dark LEDs; there is no special case.
- Changes to limite while mostrando=1 are ignored.
- iniciar while mostrando=1 is ignored. iniciar held high continuously re-triggers from OCIOSO after each FIM.
- limite=F shows 16 steps. endereco never wraps, because FIM is taken at F.
- Reset mid-playback: immediate return to the reset state; leds go dark in the same cycle.

Optional Feature:
- Macro: MOSTRA_ABORTA_EN.
- Defined: the abortar port exists. abortar=1 in any state other than OCIOSO or FIM → OCIOSO on the next edge, with leds=0 and endereco=0, and no fim_mostra pulse. abortar has priority over all other transitions. It is ignored in OCIOSO and FIM.
- Undefined: the port is absent, and playback always runs to FIM.

Test Plan:
- Bench parameters: T_ACESO=3, T_APAGADO=2.
- Reset then idle: leds=0, endereco=0, mostrando=0, db_estado=0. Hold iniciar=0 for 10 cycles → no change.
- limite=0, ROM[0]=0001, pulse iniciar → leds=0001 for exactly 3 cycles, then 0 for 2 cycles. fim_mostra is high only in cycle 7, then mostrando=0.
- limite=2, ROM=0001,0010,0100 → endereco steps 0,1,2. The LED patterns appear in order, each for 3 cycles, with 2-cycle dark gaps. fim_mostra is high in cycle 21, once only.
- Change limite 2→5 and pulse iniciar again during playback → still 3 steps and a single fim_mostra.
- Assert reset in ACENDE of step 1 → leds=0 and db_estado=0 immediately. A new iniciar restarts from endereco 0.
- With MOSTRA_ABORTA_EN: abortar=1 during APAGA of step 0, limite=3 → OCIOSO next cycle, no fim_mostra, endereco=0.
